ex: RTL and testbench
=====================

// Module: ex
// PURPOSE
//  - Execute stage of the 5-stage 32-bit MIPS pipeline: decodes ALU control, runs the ALU,
//    computes the branch target and selects the next PC.
//  - Sits between ID/EX and MEM; all outputs are registered and act as the EX/MEM pipeline register.
// PARAMETERS
//  - DW  32  datapath width (rs, rt, sign_ext, pc, results)
// PORTS
//  clk        in   1   rising-edge clock
//  reset      in   1   asynchronous, active-low reset
//  rs         in   32  operand A (register rs value)
//  rt         in   32  register rt value (operand B when ALUSrc=0)
//  sign_ext   in   32  sign-extended immediate (operand B when ALUSrc=1; branch offset in words)
//  pc         in   32  PC+4 of the instruction in EX
//  ALUSrc     in   1   0: B=rt, 1: B=sign_ext
//  ALUOp      in   2   ALU operation class from main control
//  funct      in   6   instruction funct field (used when ALUOp=2'b10)
//  branch     in   1   instruction is a beq
//  address    out  32  registered branch target
//  zero       out  1   registered ALU-result-is-zero flag
//  resultOut  out  32  registered ALU result
//  pcout      out  32  registered next PC
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low.
//  - reset=0 (any time, mid-operation included): address, resultOut, pcout <= 0; zero <= 0.
//  - All outputs update on the rising clk edge; latency = 1 cycle from inputs; no handshake, no stall.
//  - B = ALUSrc ? sign_ext : rt.
//  - ALU control:
//    ALUOp 00 -> ADD (lw/sw); 01 -> SUB (beq); 11 -> OR (ori); 10 -> from funct:
//    100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100111 NOR, 101010 SLT (signed, result 0/1),
//    000000 SLL (B << A[4:0]), 000010 SRL (A >> B[4:0], logical); any other funct -> result 0.
//  - ADD/SUB are 32-bit modulo (wrap-around, no overflow flag/trap).
//  - zero <= (ALU result == 0), computed from the same-cycle result.
//  - address <= pc + (sign_ext << 2), 32-bit modulo; computed every cycle regardless of branch.
//  - pcout <= (branch && result==0) ? branch target : pc.
//  - Inputs X/undefined propagate; no input sanitising required.
// STRUCTURE
//  - Shared package ex_pkg: ALUOp encodings, funct constants, internal ALU-op enum.
//  - One sub-module: ex_alu (combinational: op, A, B -> result, zero); control decode,
//    operand mux, branch adder and output registers live in ex.
// TESTING
//  - reset=0 with live inputs -> all outputs 0; release reset -> outputs follow inputs next edge.
//  - rs=5, sign_ext=5, ALUSrc=1, ALUOp=10, funct=000010, pc=4, branch=1 -> resultOut=0, zero=1,
//    address=24, pcout=24.
//  - rs=7, rt=3, ALUSrc=0, ALUOp=10, funct=100010 -> resultOut=4, zero=0; branch=1 -> pcout=pc.
//  - ALUOp=00, rs=32'hFFFF_FFFF, sign_ext=1, ALUSrc=1 -> resultOut=0, zero=1 (wrap); branch=0 -> pcout=pc.
//  - ALUOp=10 funct=101010, rs=-1, rt=1 -> resultOut=1; funct=111111 -> resultOut=0, zero=1.
//  - Assert reset=0 asynchronously between clock edges -> outputs clear immediately, not at next edge.

Source files
------------

// File: rtl/ex_pkg.sv
// ---------------------------------------------------------------------------
// ex_pkg
//   Shared definitions for the MIPS execute stage: main-control ALUOp
//   encodings, R-type funct codes and the internal ALU operation enum.
// ---------------------------------------------------------------------------
package ex_pkg;

   // ALUOp classes produced by main control
   localparam logic [1:0] ALUOP_ADD   = 2'b00;  // lw / sw address calc
   localparam logic [1:0] ALUOP_SUB   = 2'b01;  // beq compare
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;  // R-type, decode funct
   localparam logic [1:0] ALUOP_OR    = 2'b11;  // ori

   // R-type funct field codes
   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_NOR = 6'b100111;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;
   localparam logic [5:0] FUNCT_SLL = 6'b000000;
   localparam logic [5:0] FUNCT_SRL = 6'b000010;

   // Internal ALU operation selected by the control decode
   typedef enum logic [3:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_NOR,
      ALU_SLT,
      ALU_SLL,
      ALU_SRL,
      ALU_NONE    // unsupported funct: result forced to 0
   } alu_op_e;

endpackage

// File: rtl/ex_alu.sv
// ---------------------------------------------------------------------------
// ex_alu
//   Combinational 32-bit ALU for the execute stage.
//   Ports:
//     op      in   alu_op_e  operation to perform
//     a       in   DW        operand A (rs)
//     b       in   DW        operand B (rt or immediate)
//     result  out  DW        ALU result
//     zero    out  1         result == 0
// ---------------------------------------------------------------------------
module ex_alu
   import ex_pkg::*;
#(
   parameter int unsigned DW = 32
) (
   input  alu_op_e       op,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   output logic [DW-1:0] result,
   output logic          zero
);

   logic slt_bit;

   always_comb begin
      slt_bit = ($signed(a) < $signed(b));
      result  = '0;
      unique case (op)
         ALU_ADD:  result = a + b;
         ALU_SUB:  result = a - b;
         ALU_AND:  result = a & b;
         ALU_OR:   result = a | b;
         ALU_NOR:  result = ~(a | b);
         ALU_SLT:  result = {{(DW-1){1'b0}}, slt_bit};
         // Shift operand roles differ: SLL shifts B by A, SRL shifts A by B
         ALU_SLL:  result = b << a[4:0];
         ALU_SRL:  result = a >> b[4:0];
         ALU_NONE: result = '0;
         default:  result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/ex.sv
// ---------------------------------------------------------------------------
// ex
//   Execute stage of the 5-stage MIPS pipeline. Decodes ALU control, runs
//   the ALU, computes the branch target and selects the next PC. All outputs
//   are registered and form the EX/MEM pipeline register.
//   Ports:
//     clk        in   1    rising-edge clock
//     reset      in   1    asynchronous active-low reset
//     rs         in   DW   operand A
//     rt         in   DW   register rt (operand B when ALUSrc=0)
//     sign_ext   in   DW   immediate (operand B when ALUSrc=1; branch offset)
//     pc         in   DW   PC+4 of the instruction in EX
//     ALUSrc     in   1    operand B select
//     ALUOp      in   2    ALU operation class
//     funct      in   6    funct field (used when ALUOp=10)
//     branch     in   1    instruction is beq
//     address    out  DW   registered branch target
//     zero       out  1    registered result-is-zero flag
//     resultOut  out  DW   registered ALU result
//     pcout      out  DW   registered next PC
// ---------------------------------------------------------------------------
module ex
   import ex_pkg::*;
#(
   parameter int unsigned DW = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [DW-1:0] rs,
   input  logic [DW-1:0] rt,
   input  logic [DW-1:0] sign_ext,
   input  logic [DW-1:0] pc,
   input  logic          ALUSrc,
   input  logic [1:0]    ALUOp,
   input  logic [5:0]    funct,
   input  logic          branch,
   output logic [DW-1:0] address,
   output logic          zero,
   output logic [DW-1:0] resultOut,
   output logic [DW-1:0] pcout
);

   alu_op_e       alu_op;
   logic [DW-1:0] op_b;
   logic [DW-1:0] alu_result;
   logic          alu_zero;

   logic [DW-1:0] address_d, address_q;
   logic          zero_d,    zero_q;
   logic [DW-1:0] result_d,  result_q;
   logic [DW-1:0] pcout_d,   pcout_q;

   // ALU control decode
   always_comb begin
      alu_op = ALU_NONE;
      unique case (ALUOp)
         ALUOP_ADD: alu_op = ALU_ADD;
         ALUOP_SUB: alu_op = ALU_SUB;
         ALUOP_OR:  alu_op = ALU_OR;
         ALUOP_FUNCT: begin
            unique case (funct)
               FUNCT_ADD: alu_op = ALU_ADD;
               FUNCT_SUB: alu_op = ALU_SUB;
               FUNCT_AND: alu_op = ALU_AND;
               FUNCT_OR:  alu_op = ALU_OR;
               FUNCT_NOR: alu_op = ALU_NOR;
               FUNCT_SLT: alu_op = ALU_SLT;
               FUNCT_SLL: alu_op = ALU_SLL;
               FUNCT_SRL: alu_op = ALU_SRL;
               default:   alu_op = ALU_NONE;
            endcase
         end
         default: alu_op = ALU_NONE;
      endcase
   end

   assign op_b = ALUSrc ? sign_ext : rt;

   ex_alu #(
      .DW (DW)
   ) u_alu (
      .op     (alu_op),
      .a      (rs),
      .b      (op_b),
      .result (alu_result),
      .zero   (alu_zero)
   );

   // Branch target is formed every cycle; only pcout depends on branch.
   always_comb begin
      address_d = pc + (sign_ext << 2);
      zero_d    = alu_zero;
      result_d  = alu_result;
      pcout_d   = (branch && alu_zero) ? address_d : pc;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         address_q <= '0;
         zero_q    <= 1'b0;
         result_q  <= '0;
         pcout_q   <= '0;
      end else begin
         address_q <= address_d;
         zero_q    <= zero_d;
         result_q  <= result_d;
         pcout_q   <= pcout_d;
      end
   end

   assign address   = address_q;
   assign zero      = zero_q;
   assign resultOut = result_q;
   assign pcout     = pcout_q;

endmodule

// File: tb/tb_ex.sv
// ---------------------------------------------------------------------------
// tb_ex
//   Directed self-checking bench for the execute stage. Inputs are driven on
//   the falling edge, outputs sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_ex;

   logic        clk;
   logic        reset;
   logic [31:0] rs, rt, sign_ext, pc;
   logic        ALUSrc;
   logic [1:0]  ALUOp;
   logic [5:0]  funct;
   logic        branch;
   logic [31:0] address, resultOut, pcout;
   logic        zero;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   ex #(
      .DW (32)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .rs        (rs),
      .rt        (rt),
      .sign_ext  (sign_ext),
      .pc        (pc),
      .ALUSrc    (ALUSrc),
      .ALUOp     (ALUOp),
      .funct     (funct),
      .branch    (branch),
      .address   (address),
      .zero      (zero),
      .resultOut (resultOut),
      .pcout     (pcout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, got running required done");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic [31:0] pcv,
                        input logic src, input logic [1:0] op,
                        input logic [5:0] fn, input logic br);
      @(negedge clk);
      rs = a; rt = b; sign_ext = imm; pc = pcv;
      ALUSrc = src; ALUOp = op; funct = fn; branch = br;
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic [31:0] res,
                            input logic z, input logic [31:0] addr,
                            input logic [31:0] npc);
      check({tag, ".result"},  resultOut, res);
      check({tag, ".zero"},    {31'd0, zero}, {31'd0, z});
      check({tag, ".address"}, address, addr);
      check({tag, ".pcout"},   pcout, npc);
   endtask

   initial begin
      // Reset held low with live inputs across edges
      reset = 1'b0;
      rs = 32'd5; rt = 32'd9; sign_ext = 32'd5; pc = 32'd4;
      ALUSrc = 1'b1; ALUOp = 2'b10; funct = 6'b000010; branch = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_all("reset", 32'd0, 1'b0, 32'd0, 32'd0);

      // Release reset; SRL 5>>5 = 0, taken branch to 4 + 20
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      check_all("srl_beq", 32'd0, 1'b1, 32'd24, 32'd24);

      // SUB 7-3 = 4, branch not taken
      drive(32'd7, 32'd3, 32'd3, 32'd100, 1'b0, 2'b10, 6'b100010, 1'b1);
      check_all("sub", 32'd4, 1'b0, 32'd112, 32'd100);

      // lw/sw ADD wrap-around to zero, branch=0 so pcout stays pc
      drive(32'hFFFF_FFFF, 32'd0, 32'd1, 32'd200, 1'b1, 2'b00, 6'b111111, 1'b0);
      check_all("add_wrap", 32'd0, 1'b1, 32'd204, 32'd200);

      // SLT signed: -1 < 1
      drive(32'hFFFF_FFFF, 32'd1, 32'd0, 32'd8, 1'b0, 2'b10, 6'b101010, 1'b0);
      check("slt_neg.result", resultOut, 32'd1);
      check("slt_neg.zero", {31'd0, zero}, 32'd0);

      // SLT signed: 3 < -2 is false
      drive(32'd3, 32'hFFFF_FFFE, 32'd0, 32'd8, 1'b0, 2'b10, 6'b101010, 1'b0);
      check("slt_pos.result", resultOut, 32'd0);

      // Unknown funct produces 0
      drive(32'h1234_5678, 32'h1111_1111, 32'd0, 32'd8, 1'b0, 2'b10, 6'b111111, 1'b0);
      check("bad_funct.result", resultOut, 32'd0);
      check("bad_funct.zero", {31'd0, zero}, 32'd1);

      // AND
      drive(32'hF0F0_1234, 32'h0FF0_FF00, 32'd0, 32'd0, 1'b0, 2'b10, 6'b100100, 1'b0);
      check("and.result", resultOut, 32'h00F0_1200);

      // ori via ALUOp=11 with immediate operand
      drive(32'h1200_0000, 32'hFFFF_FFFF, 32'h0000_0034, 32'd0, 1'b1, 2'b11, 6'b100010, 1'b0);
      check("ori.result", resultOut, 32'h1200_0034);

      // NOR
      drive(32'h0000_FFFF, 32'h00FF_0000, 32'd0, 32'd0, 1'b0, 2'b10, 6'b100111, 1'b0);
      check("nor.result", resultOut, 32'hFF00_0000);

      // SLL: B << A[4:0]
      drive(32'd31, 32'd1, 32'd0, 32'd0, 1'b0, 2'b10, 6'b000000, 1'b0);
      check("sll.result", resultOut, 32'h8000_0000);

      // SRL logical: A >> B[4:0]
      drive(32'h8000_0000, 32'd4, 32'd0, 32'd0, 1'b0, 2'b10, 6'b000010, 1'b0);
      check("srl.result", resultOut, 32'h0800_0000);

      // SUB wrap 0-1
      drive(32'd0, 32'd1, 32'd0, 32'd0, 1'b0, 2'b10, 6'b100010, 1'b0);
      check("sub_wrap.result", resultOut, 32'hFFFF_FFFF);

      // ADD funct 7FFFFFFF+1
      drive(32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0, 2'b10, 6'b100000, 1'b0);
      check("add_funct.result", resultOut, 32'h8000_0000);

      // beq taken, negative offset: 40 + (-1 << 2) = 36
      drive(32'd9, 32'd9, 32'hFFFF_FFFF, 32'd40, 1'b0, 2'b01, 6'b000000, 1'b1);
      check_all("beq_taken", 32'd0, 1'b1, 32'd36, 32'd36);

      // beq not taken
      drive(32'd9, 32'd8, 32'd8, 32'd40, 1'b0, 2'b01, 6'b000000, 1'b1);
      check_all("beq_not", 32'd1, 1'b0, 32'd72, 32'd40);

      // Asynchronous reset between edges clears outputs immediately
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      check_all("async_rst", 32'd0, 1'b0, 32'd0, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
